// File: rtl/regfile_write_scheduler_if.sv
// Writeback, issue and hazard-check signals of the register-file write scheduler.
// The scheduler takes the slave side; whatever drives the requests takes the master side.
interface regfile_write_scheduler_if #(
  parameter int num_registers = 32,
  parameter int data_width    = 64
);
  localparam int sel_w = $clog2(num_registers);

  logic                  in_req0_valid;
  logic [sel_w-1:0]      in_req0_register;
  logic [data_width-1:0] in_req0_data;
  logic                  out_req0_ready;

  logic                  in_req1_valid;
  logic [sel_w-1:0]      in_req1_register;
  logic [data_width-1:0] in_req1_data;
  logic                  out_req1_ready;

  logic                  in_issue_valid;
  logic [sel_w-1:0]      in_issue_register;

  logic [sel_w-1:0]      in_check_register_0;
  logic [sel_w-1:0]      in_check_register_1;
  logic [sel_w-1:0]      in_check_register_2;
  logic                  out_busy_0;
  logic                  out_busy_1;
  logic                  out_busy_2;

  logic                  out_write_enable;
  logic [sel_w-1:0]      out_write_register_select;
  logic [data_width-1:0] out_write_data;
  logic                  out_init_done;

  modport slave (
    input  in_req0_valid, in_req0_register, in_req0_data,
    input  in_req1_valid, in_req1_register, in_req1_data,
    input  in_issue_valid, in_issue_register,
    input  in_check_register_0, in_check_register_1, in_check_register_2,
    output out_req0_ready, out_req1_ready,
    output out_busy_0, out_busy_1, out_busy_2,
    output out_write_enable, out_write_register_select, out_write_data,
    output out_init_done
  );

  modport master (
    output in_req0_valid, in_req0_register, in_req0_data,
    output in_req1_valid, in_req1_register, in_req1_data,
    output in_issue_valid, in_issue_register,
    output in_check_register_0, in_check_register_1, in_check_register_2,
    input  out_req0_ready, out_req1_ready,
    input  out_busy_0, out_busy_1, out_busy_2,
    input  out_write_enable, out_write_register_select, out_write_data,
    input  out_init_done
  );
endinterface

// File: rtl/regfile_write_scheduler.sv
// Register-file write port owner: zero-fills every register after reset, then
// round-robins two writeback sources onto the port and tracks pending writes.
module regfile_write_scheduler #(
  parameter int num_registers = 32,
  parameter int data_width    = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  regfile_write_scheduler_if.slave    bus
);
  localparam int sel_w = $clog2(num_registers);
  localparam logic [sel_w-1:0] last_sel = sel_w'(num_registers - 1);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [sel_w-1:0]        cnt_q, cnt_d;
  logic [num_registers-1:0] busy_q, busy_d, set_vec, clr_vec;
  logic                    last_grant_q, last_grant_d;
  logic                    init_done_q, init_done_d;
  logic                    we_q, we_d;
  logic [sel_w-1:0]        sel_q, sel_d;
  logic [data_width-1:0]   data_q, data_d;

  logic                    run;
  logic                    grant0, grant1;
  logic                    ready0, ready1;
  logic                    xfer;
  logic                    issue_fire;
  logic [sel_w-1:0]        xfer_reg;
  logic [data_width-1:0]   xfer_data;

  assign run = (state_q == ST_RUN);

  // Under contention the requester that did not win last time takes the port.
  assign grant0 = bus.in_req0_valid && (!bus.in_req1_valid || last_grant_q);
  assign grant1 = bus.in_req1_valid && (!bus.in_req0_valid || !last_grant_q);
  assign ready0 = run && grant0;
  assign ready1 = run && grant1;
  assign xfer   = ready0 || ready1;

  assign xfer_reg   = ready1 ? bus.in_req1_register : bus.in_req0_register;
  assign xfer_data  = ready1 ? bus.in_req1_data     : bus.in_req0_data;
  assign issue_fire = run && bus.in_issue_valid;

  genvar gi;
  generate
    for (gi = 0; gi < num_registers; gi++) begin : g_busy
      assign set_vec[gi] = (gi != 0) && issue_fire && (bus.in_issue_register == sel_w'(gi));
      assign clr_vec[gi] = xfer && (xfer_reg == sel_w'(gi));
    end
  endgenerate

  // A same-cycle issue re-marks the register after the retiring write clears it.
  assign busy_d = (busy_q & ~clr_vec) | set_vec;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    init_done_d  = init_done_q;
    we_d         = 1'b0;
    sel_d        = sel_q;
    data_d       = data_q;
    case (state_q)
      ST_INIT: begin
        we_d   = 1'b1;
        sel_d  = cnt_q;
        data_d = '0;
        cnt_d  = cnt_q + sel_w'(1);
        if (cnt_q == last_sel) state_d = ST_RUN;
      end
      ST_RUN: begin
        init_done_d = 1'b1;
        if (xfer) begin
          we_d         = (xfer_reg != '0);
          sel_d        = xfer_reg;
          data_d       = xfer_data;
          last_grant_d = ready1;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      busy_q       <= '0;
      last_grant_q <= 1'b1;
      init_done_q  <= 1'b0;
      we_q         <= 1'b0;
      sel_q        <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      last_grant_q <= last_grant_d;
      init_done_q  <= init_done_d;
      we_q         <= we_d;
      sel_q        <= sel_d;
      data_q       <= data_d;
    end
  end

  assign bus.out_req0_ready            = ready0;
  assign bus.out_req1_ready            = ready1;
  assign bus.out_busy_0                = busy_q[bus.in_check_register_0];
  assign bus.out_busy_1                = busy_q[bus.in_check_register_1];
  assign bus.out_busy_2                = busy_q[bus.in_check_register_2];
  assign bus.out_write_enable          = we_q;
  assign bus.out_write_register_select = sel_q;
  assign bus.out_write_data            = data_q;
  assign bus.out_init_done             = init_done_q;
endmodule
